sequence_generator: RTL and testbench

Serial bit-pattern transmitter that drives the single-bit input of the Moore sequence detector in the same user project. It accepts a pattern word, length and repeat count over a valid/ready load handshake. It then shifts the pattern out one bit per clock, MSB of the active field first, with a programmable zero-gap after each repetition. It serves as on-chip stimulus for the detector and is fed from wishbone/LA-controlled registers.

---
 rtl/sequence_generator_pkg.sv | 21 ++
 rtl/sequence_generator_lfsr.sv | 32 +++
 rtl/sequence_generator.sv | 185 ++++++++++++++++++
 tb/tb_sequence_generator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial sequence generator.
// Holds the FSM state encoding, the PRBS LFSR constants and a one-step
// LFSR helper that the LFSR sub-module uses.
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_e;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Shift left; the new LSB is the XOR of the tapped bits. Output bit is the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sequence_generator_lfsr.sv
// 16-bit Fibonacci LFSR used as the PRBS bit source.
// Only instantiated by sequence_generator when SEQGEN_PRBS_EN is defined.
// load_i has priority over en_i; the caller provides a non-zero seed.
module seqgen_lfsr
  import sequence_generator_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o,
  output logic [15:0] next_o
);

  logic [15:0] state_q;

  assign state_o = state_q;
  assign next_o  = lfsr_step(state_q);

  // Seed on load, otherwise advance one step per enabled cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LFSR_DEFAULT_SEED;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (en_i) begin
      state_q <= next_o;
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter feeding the sequence detector.
// Sends the low 'len' bits of a pattern MSB-first, repeated (repeat+1)
// times, with GAP_LEN zero cycles after each repetition.
// Optional build macro: SEQGEN_PRBS_EN adds load_prbs and an LFSR bit source.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int PAT_W   = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8,
  parameter int GAP_LEN = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pattern,
  input  logic [LEN_W-1:0] load_len,
  input  logic [CNT_W-1:0] load_repeat,
`ifdef SEQGEN_PRBS_EN
  input  logic             load_prbs,
`endif
  input  logic             abort,
  output logic             sequence_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [LEN_W-1:0] PAT_LEN  = LEN_W'(PAT_W);

  seq_state_e       state_q;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic             out_q;
  logic             valid_q;
  logic             done_q;

  logic [LEN_W-1:0] len_d;
  logic             load_fire;
  logic             rep_end;
  logic [PAT_W-1:0] load_shift;
  logic [PAT_W-1:0] step_shift;
  logic [PAT_W-1:0] restart_shift;
  logic             first_bit_d;
  logic             step_bit_d;
  logic             restart_bit_d;

  assign load_ready   = (state_q == ST_IDLE) & ~abort;
  assign load_fire    = load_valid & load_ready;
  assign busy         = (state_q != ST_IDLE);
  assign sequence_out = out_q;
  assign seq_valid    = valid_q;
  assign done         = done_q;

  // Out-of-range lengths fall back to the full pattern width.
  always_comb begin
    len_d = load_len;
    if ((load_len == '0) || (load_len > PAT_LEN)) begin
      len_d = PAT_LEN;
    end
  end

  // Shifting instead of indexing keeps the index width independent of PAT_W.
  assign load_shift    = load_pattern >> (len_d - LEN_W'(1));
  assign step_shift    = pattern_q >> (idx_q - LEN_W'(1));
  assign restart_shift = pattern_q >> (len_q - LEN_W'(1));

  // A repetition ends on its last bit when there is no gap, otherwise on the last gap cycle.
  assign rep_end = ~abort &
                   (((state_q == ST_SHIFT) && (idx_q == '0) && (GAP_LEN == 0)) ||
                    ((state_q == ST_GAP) && (gap_q == '0)));

`ifdef SEQGEN_PRBS_EN
  logic        prbs_q;
  logic [15:0] seed_d;
  logic [15:0] lfsr_state;
  logic [15:0] lfsr_next;

  assign seed_d = (load_pattern[15:0] == 16'h0000) ? LFSR_DEFAULT_SEED : load_pattern[15:0];

  // The LFSR advances on every SHIFT cycle, so its MSB always matches the bit on the wire.
  seqgen_lfsr u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (load_fire & load_prbs),
    .en_i    (state_q == ST_SHIFT),
    .seed_i  (seed_d),
    .state_o (lfsr_state),
    .next_o  (lfsr_next)
  );

  // Re-entering SHIFT from GAP uses the held state; from SHIFT it uses the stepped one.
  assign first_bit_d   = load_prbs ? seed_d[15] : load_shift[0];
  assign step_bit_d    = prbs_q ? lfsr_next[15] : step_shift[0];
  assign restart_bit_d = prbs_q ? ((state_q == ST_SHIFT) ? lfsr_next[15] : lfsr_state[15])
                                : restart_shift[0];

  // Bit-source select captured with the rest of the load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prbs_q <= 1'b0;
    end else if (load_fire) begin
      prbs_q <= load_prbs;
    end
  end
`else
  assign first_bit_d   = load_shift[0];
  assign step_bit_d    = step_shift[0];
  assign restart_bit_d = restart_shift[0];
`endif

  // Main sequencing FSM with registered serial outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_fire) begin
            pattern_q <= load_pattern;
            len_q     <= len_d;
            rep_q     <= load_repeat;
            idx_q     <= len_d - LEN_W'(1);
            out_q     <= first_bit_d;
            valid_q   <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT, ST_GAP: begin
          if (abort) begin
            state_q <= ST_IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
          end else if (rep_end) begin
            if (rep_q != '0) begin
              rep_q   <= rep_q - CNT_W'(1);
              idx_q   <= len_q - LEN_W'(1);
              out_q   <= restart_bit_d;
              valid_q <= 1'b1;
              state_q <= ST_SHIFT;
            end else begin
              state_q <= ST_IDLE;
              out_q   <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (state_q == ST_SHIFT) begin
            if (idx_q != '0) begin
              idx_q <= idx_q - LEN_W'(1);
              out_q <= step_bit_d;
            end else begin
              gap_q   <= GAP_LOAD;
              out_q   <= 1'b0;
              valid_q <= 1'b0;
              state_q <= ST_GAP;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          out_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator (GAP_LEN = 1).
// Expected serial streams come from a per-transfer model built from the
// transfer rules; PRBS cases are only exercised when SEQGEN_PRBS_EN is defined.
module tb_sequence_generator;

  localparam int GAP = 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] load_pattern = '0;
  logic [4:0]  load_len = '0;
  logic [7:0]  load_repeat = '0;
`ifdef SEQGEN_PRBS_EN
  logic        load_prbs = 1'b0;
`endif
  logic        load_ready;
  logic        sequence_out;
  logic        seq_valid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  bit exp_bit[$];
  bit exp_val[$];

  always #5 clock = ~clock;

  sequence_generator #(
    .PAT_W   (16),
    .LEN_W   (5),
    .CNT_W   (8),
    .GAP_LEN (GAP)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_repeat  (load_repeat),
`ifdef SEQGEN_PRBS_EN
    .load_prbs    (load_prbs),
`endif
    .abort        (abort),
    .sequence_out (sequence_out),
    .seq_valid    (seq_valid),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int eff_len(input int len);
    return (len == 0 || len > 16) ? 16 : len;
  endfunction

  // Reference stream: (rep+1) repetitions of len bits MSB-first, each followed by GAP zeros.
  function automatic void build_model(input logic [15:0] pat, input int len, input int rep,
                                      input bit prbs);
    int          l;
    logic [15:0] s;
    l = eff_len(len);
    s = (pat == 16'h0000) ? 16'hACE1 : pat;
    exp_bit.delete();
    exp_val.delete();
    for (int r = 0; r <= rep; r++) begin
      for (int k = 0; k < l; k++) begin
        if (prbs) begin
          exp_bit.push_back(s[15]);
          s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end else begin
          exp_bit.push_back(pat[l-1-k]);
        end
        exp_val.push_back(1'b1);
      end
      for (int g = 0; g < GAP; g++) begin
        exp_bit.push_back(1'b0);
        exp_val.push_back(1'b0);
      end
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the done
  // cycle (or of the cycle after abort recovery).
  task automatic run_transfer(input logic [15:0] pat, input int len, input int rep,
                              input int abort_at, input bit prbs);
    build_model(pat, len, rep, prbs);
    check("ready_before_load", load_ready, 1'b1);
    load_valid   = 1'b1;
    load_pattern = pat;
    load_len     = len[4:0];
    load_repeat  = rep[7:0];
`ifdef SEQGEN_PRBS_EN
    load_prbs    = prbs;
`endif
    for (int c = 0; c < exp_bit.size(); c++) begin
      @(negedge clock);
      load_valid = 1'b0;
      if (abort_at >= 0 && c == abort_at + 1) begin
        abort = 1'b0;
        check("abort_out", sequence_out, 1'b0);
        check("abort_valid", seq_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clock);
        check("abort_no_done", done, 1'b0);
        check("abort_ready", load_ready, 1'b1);
        return;
      end
      check("bit", sequence_out, exp_bit[c]);
      check("valid", seq_valid, exp_val[c]);
      check("busy", busy, 1'b1);
      check("done_early", done, 1'b0);
      check("ready_busy", load_ready, 1'b0);
      load_valid   = ($urandom_range(0, 3) == 0);
      load_pattern = 16'($urandom);
      load_len     = 5'($urandom);
      if (c == abort_at) abort = 1'b1;
    end
    @(negedge clock);
    load_valid = 1'b0;
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_out", sequence_out, 1'b0);
    check("done_valid", seq_valid, 1'b0);
    check("done_ready", load_ready, 1'b1);
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_valid", seq_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l;
    int r;
    int n;
    int ab;

    #2 reset_n = 1'b0;
    #1;
    check("rst_out", sequence_out, 1'b0);
    check("rst_valid", seq_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", load_ready, 1'b1);
    check("post_rst_done", done, 1'b0);

    run_transfer(16'h000F, 4, 0, -1, 1'b0);
    run_transfer(16'h0005, 3, 2, -1, 1'b0);   // back-to-back: load in the done cycle
    idle_cycle();
    run_transfer(16'h8001, 0, 0, -1, 1'b0);
    run_transfer(16'h8001, 31, 0, -1, 1'b0);
    idle_cycle();
    run_transfer(16'h1234, 16, 1, 1, 1'b0);   // abort while the 2nd bit is on the wire

    abort      = 1'b1;
    load_valid = 1'b1;
    load_len   = 5'd4;
    #1 check("abort_blocks_ready", load_ready, 1'b0);
    @(negedge clock);
    abort      = 1'b0;
    load_valid = 1'b0;
    check("abort_blocks_load", busy, 1'b0);
    check("abort_blocks_valid", seq_valid, 1'b0);

    load_valid   = 1'b1;
    load_pattern = 16'h00FF;
    load_len     = 5'd8;
    load_repeat  = 8'd0;
    @(negedge clock);
    load_valid = 1'b0;
    @(negedge clock);
    check("pre_rst_out", sequence_out, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out", sequence_out, 1'b0);
    check("mid_rst_valid", seq_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    check("rel_ready", load_ready, 1'b1);
    idle_cycle();
    idle_cycle();

    for (int t = 0; t < 40; t++) begin
      l = $urandom_range(0, 31);
      r = $urandom_range(0, 3);
      n = (r + 1) * (eff_len(l) + GAP);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 2) : -1;
      if ($urandom_range(0, 1) == 1) idle_cycle();
      run_transfer(16'($urandom), l, r, ab, 1'b0);
    end

`ifdef SEQGEN_PRBS_EN
    idle_cycle();
    run_transfer(16'h0000, 16, 1, -1, 1'b1);
    run_transfer(16'($urandom), 7, 2, -1, 1'b1);
    run_transfer(16'h0005, 3, 1, -1, 1'b0);
`endif

    idle_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
